sram_port_arbiter: RTL and testbench

//   Shares the single dual-SRAM access port (re/we/addr/data_in/done/data_out) between two requesters,
//   e.g. the RAM test state machine (m0) and the UART loader (m1). Round-robin arbitration, one

---
 rtl/sram_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_sram_port_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one SRAM controller port between two req/ack masters.
// Optional WAIT-state watchdog enabled by defining SRAM_ARB_TIMEOUT_EN.
module sram_port_arbiter #(
    parameter int ADDR_W  = 17,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              ram_re,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic              ram_done,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              grant,
    output logic              timeout_err
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

    state_t            state, state_nxt;
    logic              last_m1;
    logic              lat_we;
    logic              start;
    logic              pick_m1;
    logic              timed_out;
    logic [DATA_W-1:0] rd_val;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    assign start   = (state == S_IDLE) && (m0_req || m1_req);
    // On a tie the master that was not served last wins.
    assign pick_m1 = m1_req && (!m0_req || !last_m1);

`ifdef SRAM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_q;

    // ram_done in the limit cycle takes priority over the watchdog.
    assign timed_out   = (state == S_WAIT) && !ram_done && (wait_cnt == CNT_W'(TIMEOUT - 1));
    assign timeout_err = timeout_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == S_ISSUE)
                wait_cnt <= '0;
            else if (state == S_WAIT)
                wait_cnt <= wait_cnt + 1'b1;
            if (timed_out)
                timeout_q <= 1'b1;
        end
    end
`else
    assign timed_out   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign rd_val = ram_done ? ram_rdata : DATA_W'(16'hDEAD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        ram_re    = 1'b0;
        ram_we    = 1'b0;
        m0_ack    = 1'b0;
        m1_ack    = 1'b0;
        busy      = (state != S_IDLE);
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_ISSUE;
            S_ISSUE: begin
                ram_re    = !lat_we;
                ram_we    = lat_we;
                state_nxt = S_WAIT;
            end
            S_WAIT:  if (ram_done || timed_out) state_nxt = S_ACK;
            S_ACK: begin
                m0_ack    = !grant;
                m1_ack    = grant;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant     <= 1'b0;
            last_m1   <= 1'b1;
            lat_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            if (start) begin
                grant     <= pick_m1;
                last_m1   <= pick_m1;
                lat_we    <= pick_m1 ? m1_we    : m0_we;
                ram_addr  <= pick_m1 ? m1_addr  : m0_addr;
                ram_wdata <= pick_m1 ? m1_wdata : m0_wdata;
            end
            // Read data lands on the winner's port at the WAIT->ACK edge.
            if ((state == S_WAIT) && !lat_we && (ram_done || timed_out)) begin
                if (grant)
                    m1_rdata <= rd_val;
                else
                    m0_rdata <= rd_val;
            end
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed self-checking bench for sram_port_arbiter with a small SRAM controller stand-in.
module tb_sram_port_arbiter;

    localparam int ADDR_W  = 17;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              m0_req = 1'b0, m0_we = 1'b0;
    logic [ADDR_W-1:0] m0_addr = '0;
    logic [DATA_W-1:0] m0_wdata = '0;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_rdata;
    logic              m1_req = 1'b0, m1_we = 1'b0;
    logic [ADDR_W-1:0] m1_addr = '0;
    logic [DATA_W-1:0] m1_wdata = '0;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_rdata;
    logic              ram_re, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_done = 1'b0;
    logic [DATA_W-1:0] ram_rdata = 16'h5A5A;
    logic              busy, grant, timeout_err;

    int total = 0;
    int bad   = 0;

    sram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .ram_re(ram_re), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_done(ram_done), .ram_rdata(ram_rdata),
        .busy(busy), .grant(grant), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Controller stand-in: ram_done arrives done_delay cycles after the strobe cycle.
    int                done_delay = 1;
    bit                never_done = 1'b0;
    int                cd;
    bit                pend;
    logic [DATA_W-1:0] pend_data;
    logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_done  <= 1'b0;
            ram_rdata <= 16'h5A5A;
            pend = 1'b0;
            cd   = 0;
        end else begin
            ram_done  <= 1'b0;
            ram_rdata <= 16'h5A5A;
            if (ram_we) mem[ram_addr] = ram_wdata;
            if (ram_re || ram_we) begin
                pend      = !never_done;
                cd        = done_delay;
                pend_data = (ram_re && mem.exists(ram_addr)) ? mem[ram_addr] : 16'h0000;
            end
            if (pend) begin
                cd--;
                if (cd <= 0) begin
                    ram_done  <= 1'b1;
                    ram_rdata <= pend_data;
                    pend = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Drives one transaction for master m and records what the port did; caller checks.
    task automatic run_txn(input bit m, input bit we, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wd, input int max_cyc,
                           output int strobe_at, output int ack_at, output int n_strobe,
                           output int n_other_ack, output bit s_we,
                           output logic [ADDR_W-1:0] s_addr, output logic [DATA_W-1:0] s_wdata);
        strobe_at = -1; ack_at = -1; n_strobe = 0; n_other_ack = 0;
        s_we = 1'b0; s_addr = '0; s_wdata = '0;
        if (!m) begin m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wd; end
        else    begin m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wd; end
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge clk);
            if (ram_re || ram_we) begin
                n_strobe++;
                if (strobe_at < 0) begin
                    strobe_at = i; s_we = ram_we; s_addr = ram_addr; s_wdata = ram_wdata;
                end
            end
            if (m ? m0_ack : m1_ack) n_other_ack++;
            if (m ? m1_ack : m0_ack) begin ack_at = i; break; end
        end
        if (!m) m0_req = 1'b0; else m1_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({ram_re, ram_we, busy, grant, m0_ack, m1_ack, timeout_err} !== 7'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=0000000",
                     {ram_re, ram_we, busy, grant, m0_ack, m1_ack, timeout_err});
        end
        total++;
        if ({ram_addr, ram_wdata, m0_rdata, m1_rdata} !== '0) begin
            bad++;
            $display("FAIL reset_data addr=%h wdata=%h r0=%h r1=%h want all 0",
                     ram_addr, ram_wdata, m0_rdata, m1_rdata);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_write_read();
        int s, a, ns, no; bit sw; logic [ADDR_W-1:0] sa; logic [DATA_W-1:0] sd;
        done_delay = 2;
        run_txn(1'b0, 1'b1, 17'h00005, 16'h1234, 30, s, a, ns, no, sw, sa, sd);
        total++;
        if (ns !== 1 || sw !== 1'b1) begin
            bad++; $display("FAIL wr_strobe count=%0d is_write=%0d want 1/1", ns, sw);
        end
        total++;
        if (sa !== 17'h00005 || sd !== 16'h1234) begin
            bad++; $display("FAIL wr_addr_data got=%h/%h want 00005/1234", sa, sd);
        end
        total++;
        if (a < 0 || a - s !== 3) begin
            bad++; $display("FAIL wr_ack_latency strobe=%0d ack=%0d want ack=strobe+3", s, a);
        end
        done_delay = 1;
        run_txn(1'b1, 1'b0, 17'h00005, 16'h0000, 30, s, a, ns, no, sw, sa, sd);
        total++;
        if (a < 0 || m1_rdata !== 16'h1234) begin
            bad++; $display("FAIL rd_m1_rdata ack=%0d got=%h want 1234", a, m1_rdata);
        end
        total++;
        if (m0_rdata !== 16'h0000 || no !== 0) begin
            bad++; $display("FAIL rd_m0_untouched r0=%h m0_acks=%0d want 0000/0", m0_rdata, no);
        end
    endtask

    task automatic test_ram2_select();
        int s, a, ns, no; bit sw; logic [ADDR_W-1:0] sa; logic [DATA_W-1:0] sd;
        run_txn(1'b0, 1'b1, 17'h10003, 16'hBEEF, 30, s, a, ns, no, sw, sa, sd);
        total++;
        if (a < 0 || sa !== 17'h10003) begin
            bad++; $display("FAIL ram2_addr ack=%0d got=%h want 10003", a, sa);
        end
        run_txn(1'b0, 1'b0, 17'h10003, 16'h0000, 30, s, a, ns, no, sw, sa, sd);
        total++;
        if (a < 0 || m0_rdata !== 16'hBEEF) begin
            bad++; $display("FAIL ram2_readback ack=%0d got=%h want beef", a, m0_rdata);
        end
    endtask

    task automatic test_round_robin();
        int order[4]; int igr[4]; int n_ack = 0; int n_iss = 0; int both = 0;
        for (int k = 0; k < 4; k++) begin order[k] = -1; igr[k] = -1; end
        apply_reset();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 17'h00005;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 17'h10003;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if ((ram_re || ram_we) && n_iss < 4) begin igr[n_iss] = int'(grant); n_iss++; end
            if (m0_ack && m1_ack) both++;
            if (m0_ack && n_ack < 4) begin order[n_ack] = 0; n_ack++; end
            else if (m1_ack && n_ack < 4) begin order[n_ack] = 1; n_ack++; end
            if (n_ack == 4) break;
        end
        m0_req = 1'b0; m1_req = 1'b0;
        total++;
        if (n_ack !== 4 || both !== 0) begin
            bad++; $display("FAIL rr_ack_count got=%0d double=%0d want 4/0", n_ack, both);
        end
        for (int k = 0; k < 4; k++) begin
            total++;
            if (order[k] !== k % 2 || igr[k] !== k % 2) begin
                bad++;
                $display("FAIL rr_order step=%0d ack_from=%0d grant=%0d want %0d",
                         k, order[k], igr[k], k % 2);
            end
        end
        total++;
        if (m0_rdata !== 16'h1234 || m1_rdata !== 16'hBEEF) begin
            bad++; $display("FAIL rr_rdata r0=%h r1=%h want 1234/beef", m0_rdata, m1_rdata);
        end
    endtask

    task automatic test_back_to_back();
        int t[3]; int n = 0; int gbad = 0; int m0c = 0;
        for (int k = 0; k < 3; k++) t[k] = 0;
        done_delay = 1;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 17'h00005;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (m0_ack) m0c++;
            if (m1_ack) begin
                t[n] = i;
                if (grant !== 1'b1) gbad++;
                n++;
                if (n == 3) break;
            end
        end
        m1_req = 1'b0;
        total++;
        if (n !== 3 || t[1] - t[0] !== 4 || t[2] - t[1] !== 4) begin
            bad++;
            $display("FAIL b2b_spacing acks=%0d at %0d,%0d,%0d want 3 acks 4 apart",
                     n, t[0], t[1], t[2]);
        end
        total++;
        if (gbad !== 0 || m0c !== 0 || m1_rdata !== 16'h1234) begin
            bad++;
            $display("FAIL b2b_grant bad_grant=%0d m0_acks=%0d r1=%h want 0/0/1234",
                     gbad, m0c, m1_rdata);
        end
    endtask

    task automatic test_reset_in_wait();
        int s, a, ns, no; int acks = 0; int busy_seen = 0; int seen = 0;
        bit sw; logic [ADDR_W-1:0] sa; logic [DATA_W-1:0] sd;
        never_done = 1'b1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 17'h00005;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            @(negedge clk);
            if (ram_re) seen = 1;
        end
        @(negedge clk);
        total++;
        if (seen !== 1 || busy !== 1'b1) begin
            bad++; $display("FAIL rst_wait_setup strobe=%0d busy=%b want 1/1", seen, busy);
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if ({ram_re, ram_we, busy, m0_ack, m1_ack, grant} !== 6'b0 || m0_rdata !== 16'h0000) begin
            bad++;
            $display("FAIL rst_async ctrl=%b r0=%h want 000000/0000",
                     {ram_re, ram_we, busy, m0_ack, m1_ack, grant}, m0_rdata);
        end
        m0_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        never_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) acks++;
            if (busy) busy_seen++;
        end
        total++;
        if (acks !== 0 || busy_seen !== 0) begin
            bad++; $display("FAIL rst_no_ack acks=%0d busy_cycles=%0d want 0/0", acks, busy_seen);
        end
        run_txn(1'b1, 1'b0, 17'h10003, 16'h0000, 30, s, a, ns, no, sw, sa, sd);
        total++;
        if (a < 0 || a - s !== 2 || m1_rdata !== 16'hBEEF) begin
            bad++;
            $display("FAIL rst_recover strobe=%0d ack=%0d r1=%h want ack=strobe+2 beef", s, a, m1_rdata);
        end
    endtask

    task automatic test_timeout();
        int s, a, ns, no; bit sw; logic [ADDR_W-1:0] sa; logic [DATA_W-1:0] sd;
        apply_reset();
        never_done = 1'b1;
        run_txn(1'b0, 1'b0, 17'h00005, 16'h0000, 100, s, a, ns, no, sw, sa, sd);
`ifdef SRAM_ARB_TIMEOUT_EN
        total++;
        if (a < 0 || a - s !== TIMEOUT + 1 || ns !== 1) begin
            bad++;
            $display("FAIL to_latency strobe=%0d ack=%0d strobes=%0d want ack=strobe+%0d, 1",
                     s, a, ns, TIMEOUT + 1);
        end
        @(negedge clk);
        total++;
        if (m0_rdata !== 16'hDEAD || timeout_err !== 1'b1) begin
            bad++; $display("FAIL to_result r0=%h err=%b want dead/1", m0_rdata, timeout_err);
        end
        repeat (3) @(negedge clk);
        total++;
        if (timeout_err !== 1'b1) begin
            bad++; $display("FAIL to_sticky err=%b want 1", timeout_err);
        end
        apply_reset();
        total++;
        if (timeout_err !== 1'b0) begin
            bad++; $display("FAIL to_clear err=%b want 0", timeout_err);
        end
`else
        total++;
        if (a !== -1 || busy !== 1'b1 || timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL to_hang ack=%0d busy=%b err=%b want -1/1/0", a, busy, timeout_err);
        end
        apply_reset();
`endif
        never_done = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_ram2_select();
        test_round_robin();
        test_back_to_back();
        test_reset_in_wait();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
